// File: rtl/vram_arbiter.sv
// vram_arbiter
//   Shares a single-port 16Kx4 synchronous video RAM between VGA scan-out
//   nibble fetches (fixed 2-cycle latency, priority) and a CPU
//   request/acknowledge port. A starvation guard forces a waiting CPU
//   operation through after CPU_MAX_WAIT lost arbitrations, dropping the
//   colliding VGA fetch and setting the sticky vga_overrun flag.
//
// Ports:
//   vclk, reset_n            pixel clock, synchronous active-low reset
//   vga_req, vga_a           one-cycle fetch strobe and nibble address
//   vga_do, vga_valid        fetched nibble (held) and its one-cycle strobe
//   vga_overrun              sticky: a VGA fetch was dropped by the guard
//   cpu_req/we/a/di          level request, direction, address, write data
//   cpu_do, cpu_ack          read data (held) and one-cycle completion pulse
//   ram_a/we/di              registered RAM address, write enable, data
//   ram_do                   RAM read data, one cycle after ram_a
module vram_arbiter #(
    parameter int unsigned CPU_MAX_WAIT = 4
) (
    input  logic        vclk,
    input  logic        reset_n,
    input  logic        vga_req,
    input  logic [13:0] vga_a,
    output logic [3:0]  vga_do,
    output logic        vga_valid,
    output logic        vga_overrun,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [13:0] cpu_a,
    input  logic [3:0]  cpu_di,
    output logic [3:0]  cpu_do,
    output logic        cpu_ack,
    output logic [13:0] ram_a,
    output logic        ram_we,
    output logic [3:0]  ram_di,
    input  logic [3:0]  ram_do
);

    localparam logic [3:0] MAX_WAIT = 4'(CPU_MAX_WAIT);

    // Tag of the access issued at each of the last two edges. A CPU write
    // only needs one stage (ack after E1); reads are captured from the
    // second stage when ram_do carries their data.
    typedef enum logic [1:0] {
        TAG_NONE,
        TAG_VGA,
        TAG_CPU_RD,
        TAG_CPU_WR
    } tag_t;

    tag_t        tag1;
    tag_t        tag2;
    logic        busy;
    logic [3:0]  wait_cnt;

    logic        cpu_pending;
    logic        guard_fire;
    logic        issue_vga;
    logic        issue_cpu;

    always_comb begin
        cpu_pending = cpu_req && !busy;
        guard_fire  = cpu_pending && vga_req && (wait_cnt == MAX_WAIT);
        issue_vga   = vga_req && !guard_fire;
        issue_cpu   = cpu_pending && !issue_vga;
    end

    always_ff @(posedge vclk) begin
        if (!reset_n) begin
            vga_do      <= '0;
            vga_valid   <= 1'b0;
            vga_overrun <= 1'b0;
            cpu_do      <= '0;
            cpu_ack     <= 1'b0;
            ram_a       <= '0;
            ram_we      <= 1'b0;
            ram_di      <= '0;
            busy        <= 1'b0;
            wait_cnt    <= '0;
            tag1        <= TAG_NONE;
            tag2        <= TAG_NONE;
        end else begin
            vga_valid <= 1'b0;
            cpu_ack   <= 1'b0;

            // Issue stage
            if (issue_vga) begin
                ram_a  <= vga_a;
                ram_we <= 1'b0;
                tag1   <= TAG_VGA;
            end else if (issue_cpu) begin
                ram_a  <= cpu_a;
                ram_we <= cpu_we;
                ram_di <= cpu_di;
                busy   <= 1'b1;
                tag1   <= cpu_we ? TAG_CPU_WR : TAG_CPU_RD;
            end else begin
                ram_we <= 1'b0;
                tag1   <= TAG_NONE;
            end

            tag2 <= tag1;

            // Completion: busy is only ever set while it was clear, so the
            // clears below never coincide with a new CPU issue.
            if (tag1 == TAG_CPU_WR) begin
                cpu_ack <= 1'b1;
                busy    <= 1'b0;
            end

            if (tag2 == TAG_VGA) begin
                vga_do    <= ram_do;
                vga_valid <= 1'b1;
            end else if (tag2 == TAG_CPU_RD) begin
                cpu_do  <= ram_do;
                cpu_ack <= 1'b1;
                busy    <= 1'b0;
            end

            // Starvation guard
            if (issue_cpu || !cpu_req) begin
                wait_cnt <= '0;
            end else if (cpu_pending && issue_vga) begin
                wait_cnt <= wait_cnt + 4'd1;
            end

            if (guard_fire) begin
                vga_overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter
//   Scoreboard bench for vram_arbiter: expected VGA and CPU completions are
//   queued with their expected edge when stimulus is driven, and a negedge
//   monitor pops and compares them when vga_valid / cpu_ack appear.
module tb_vram_arbiter;

    logic        vclk = 1'b0;
    logic        reset_n;
    logic        vga_req;
    logic [13:0] vga_a;
    logic [3:0]  vga_do;
    logic        vga_valid;
    logic        vga_overrun;
    logic        cpu_req;
    logic        cpu_we;
    logic [13:0] cpu_a;
    logic [3:0]  cpu_di;
    logic [3:0]  cpu_do;
    logic        cpu_ack;
    logic [13:0] ram_a;
    logic        ram_we;
    logic [3:0]  ram_di;
    logic [3:0]  ram_do;

    vram_arbiter #(.CPU_MAX_WAIT(4)) dut (
        .vclk        (vclk),
        .reset_n     (reset_n),
        .vga_req     (vga_req),
        .vga_a       (vga_a),
        .vga_do      (vga_do),
        .vga_valid   (vga_valid),
        .vga_overrun (vga_overrun),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_a       (cpu_a),
        .cpu_di      (cpu_di),
        .cpu_do      (cpu_do),
        .cpu_ack     (cpu_ack),
        .ram_a       (ram_a),
        .ram_we      (ram_we),
        .ram_di      (ram_di),
        .ram_do      (ram_do)
    );

    always #5 vclk = ~vclk;

    function automatic logic [3:0] pat(input logic [13:0] a);
        return a[3:0] ^ a[7:4] ^ a[13:10];
    endfunction

    // Synchronous RAM model: read-before-write, one-cycle read latency
    logic [3:0] mem [0:16383];
    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = pat(14'(i));
        forever begin
            @(posedge vclk);
            ram_do <= mem[ram_a];
            if (ram_we === 1'b1) mem[ram_a] = ram_di;
        end
    end

    // Expected RAM contents, maintained by the stimulus only
    logic [3:0] exp_mem [0:16383];

    typedef struct {
        logic [3:0] data;
        int         edge_no;
        bit         exact;
        bit         is_read;
    } exp_t;

    exp_t vga_q[$];
    exp_t cpu_q[$];

    int n_tests  = 0;
    int n_fail   = 0;
    int edge_cnt = 0;
    int vga_cnt  = 0;

    always @(posedge vclk) edge_cnt++;

    task automatic tick();
        @(posedge vclk);
        #1;
    endtask

    task automatic push_vga(input logic [3:0] d, input int e);
        exp_t x;
        x.data = d; x.edge_no = e; x.exact = 1'b1; x.is_read = 1'b1;
        vga_q.push_back(x);
    endtask

    task automatic push_cpu(input bit rd, input logic [3:0] d, input int e, input bit ex);
        exp_t x;
        x.data = d; x.edge_no = e; x.exact = ex; x.is_read = rd;
        cpu_q.push_back(x);
    endtask

    // Output monitor / scoreboard checker
    exp_t m;
    always @(negedge vclk) begin
        if (vga_valid === 1'b1) begin
            vga_cnt++;
            n_tests++;
            if (vga_q.size() == 0) begin
                n_fail++;
                $display("FAIL vga_unexpected: vga_valid=1 at edge %0d, want no pulse", edge_cnt);
            end else begin
                m = vga_q.pop_front();
                if (vga_do !== m.data || edge_cnt != m.edge_no) begin
                    n_fail++;
                    $display("FAIL vga_fetch: got %h at edge %0d, want %h at edge %0d",
                             vga_do, edge_cnt, m.data, m.edge_no);
                end
            end
        end
        if (cpu_ack === 1'b1) begin
            n_tests++;
            if (cpu_q.size() == 0) begin
                n_fail++;
                $display("FAIL cpu_unexpected: cpu_ack=1 at edge %0d, want no pulse", edge_cnt);
            end else begin
                m = cpu_q.pop_front();
                if ((m.exact ? (edge_cnt != m.edge_no) : (edge_cnt > m.edge_no)) ||
                    (m.is_read && cpu_do !== m.data)) begin
                    n_fail++;
                    $display("FAIL cpu_op: got do=%h at edge %0d, want do=%h at edge %0d%s",
                             cpu_do, edge_cnt, m.data, m.edge_no, m.exact ? "" : " or earlier");
                end
            end
        end
    end

    task automatic wait_ack(input string name);
        bit got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            tick();
            if (cpu_ack === 1'b1) got = 1'b1;
        end
        cpu_req = 1'b0;
        n_tests++;
        if (!got) begin
            n_fail++;
            $display("FAIL %s_ack_timeout: cpu_ack got 0, want 1 within 10 cycles", name);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        n_tests++;
        if ({vga_do, vga_valid, vga_overrun, cpu_do, cpu_ack, ram_a, ram_we, ram_di} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got do=%h v=%b ovr=%b cdo=%h ack=%b a=%h we=%b di=%h, want all 0",
                     vga_do, vga_valid, vga_overrun, cpu_do, cpu_ack, ram_a, ram_we, ram_di);
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_cpu_write_read();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_a = 14'h0123; cpu_di = 4'hA;
        push_cpu(1'b0, 4'h0, edge_cnt + 2, 1'b1);
        exp_mem[14'h0123] = 4'hA;
        tick();
        n_tests++;
        if (ram_we !== 1'b1 || ram_a !== 14'h0123 || ram_di !== 4'hA) begin
            n_fail++;
            $display("FAIL wr_issue: got we=%b a=%h di=%h, want we=1 a=0123 di=a", ram_we, ram_a, ram_di);
        end
        tick();
        cpu_req = 1'b0;
        n_tests++;
        if (ram_we !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_pulse_len: ram_we got %b one cycle later, want 0", ram_we);
        end
        tick();
        cpu_req = 1'b1; cpu_we = 1'b0;
        push_cpu(1'b1, 4'hA, edge_cnt + 3, 1'b1);
        tick();
        n_tests++;
        if (ram_we !== 1'b0 || ram_a !== 14'h0123) begin
            n_fail++;
            $display("FAIL rd_issue: got we=%b a=%h, want we=0 a=0123", ram_we, ram_a);
        end
        wait_ack("rd");
        repeat (2) tick();
    endtask

    task automatic test_simultaneous();
        vga_req = 1'b1; vga_a = 14'h2045;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_a = 14'h0123;
        push_vga(exp_mem[14'h2045], edge_cnt + 3);
        push_cpu(1'b1, exp_mem[14'h0123], edge_cnt + 4, 1'b1);
        tick();
        vga_req = 1'b0;
        n_tests++;
        if (ram_a !== 14'h2045 || ram_we !== 1'b0) begin
            n_fail++;
            $display("FAIL sim_vga_first: got a=%h we=%b, want a=2045 we=0", ram_a, ram_we);
        end
        tick();
        n_tests++;
        if (ram_a !== 14'h0123) begin
            n_fail++;
            $display("FAIL sim_cpu_second: got a=%h, want a=0123", ram_a);
        end
        wait_ack("sim");
        repeat (2) tick();
    endtask

    task automatic test_scanout();
        int base = vga_cnt;
        int k = 0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_a = 14'h1000;
        push_cpu(1'b1, exp_mem[cpu_a], edge_cnt + 4, 1'b0);
        for (int i = 0; i < 640; i++) begin
            vga_req = (i % 4 == 0);
            vga_a = 14'h0200 + 14'(i / 4);
            if (vga_req) push_vga(exp_mem[vga_a], edge_cnt + 3);
            tick();
            vga_req = 1'b0;
            if (cpu_ack === 1'b1) begin
                if (i < 636) begin
                    k++;
                    cpu_a = 14'h1000 + 14'(k);
                    push_cpu(1'b1, exp_mem[cpu_a], edge_cnt + 4, 1'b0);
                end else begin
                    cpu_req = 1'b0;
                end
            end
        end
        if (cpu_req) wait_ack("scan");
        repeat (4) tick();
        n_tests++;
        if (vga_cnt - base != 160) begin
            n_fail++;
            $display("FAIL scan_vga_count: got %0d pulses, want 160", vga_cnt - base);
        end
        n_tests++;
        if (vga_overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL scan_overrun: got %b, want 0", vga_overrun);
        end
    endtask

    task automatic test_guard();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_a = 14'h0456; cpu_di = 4'h7;
        for (int i = 0; i < 8; i++) begin
            vga_req = 1'b1;
            vga_a = 14'h0300 + 14'(i);
            if (i != 4) push_vga(exp_mem[vga_a], edge_cnt + 3);
            tick();
            if (i == 3) begin
                n_tests++;
                if (vga_overrun !== 1'b0) begin
                    n_fail++;
                    $display("FAIL guard_early: vga_overrun got %b after 4 waits, want 0", vga_overrun);
                end
            end
            if (i == 4) begin
                exp_mem[14'h0456] = 4'h7;
                push_cpu(1'b0, 4'h0, edge_cnt + 1, 1'b1);
                n_tests++;
                if (ram_we !== 1'b1 || ram_a !== 14'h0456 || ram_di !== 4'h7 || vga_overrun !== 1'b1) begin
                    n_fail++;
                    $display("FAIL guard_force: got we=%b a=%h di=%h ovr=%b, want we=1 a=0456 di=7 ovr=1",
                             ram_we, ram_a, ram_di, vga_overrun);
                end
            end
            if (cpu_ack === 1'b1) cpu_req = 1'b0;
        end
        vga_req = 1'b0;
        repeat (6) tick();
        n_tests++;
        if (vga_overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL guard_sticky: vga_overrun got %b, want 1", vga_overrun);
        end
    endtask

    task automatic test_reset_inflight();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_a = 14'h0123;
        tick();
        reset_n = 1'b0;
        tick();
        cpu_req = 1'b0;
        tick();
        n_tests++;
        if ({vga_do, vga_valid, vga_overrun, cpu_do, cpu_ack, ram_a, ram_we, ram_di} !== '0) begin
            n_fail++;
            $display("FAIL rst_outputs: got do=%h v=%b ovr=%b cdo=%h ack=%b a=%h we=%b di=%h, want all 0",
                     vga_do, vga_valid, vga_overrun, cpu_do, cpu_ack, ram_a, ram_we, ram_di);
        end
        reset_n = 1'b1;
        repeat (4) tick();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_a = 14'h3000;
        push_cpu(1'b1, exp_mem[14'h3000], edge_cnt + 3, 1'b1);
        wait_ack("rst_after");
        repeat (2) tick();
    endtask

    task automatic test_back_to_back_raw();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_a = 14'h3FFF; cpu_di = 4'h5;
        exp_mem[14'h3FFF] = 4'h5;
        push_cpu(1'b0, 4'h0, edge_cnt + 2, 1'b1);
        tick();
        vga_req = 1'b1; vga_a = 14'h3FFF;
        push_vga(4'h5, edge_cnt + 3);
        tick();
        vga_req = 1'b0;
        cpu_req = 1'b0;
        n_tests++;
        if (ram_a !== 14'h3FFF || ram_we !== 1'b0) begin
            n_fail++;
            $display("FAIL raw_vga_issue: got a=%h we=%b, want a=3fff we=0", ram_a, ram_we);
        end
        repeat (4) tick();
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) exp_mem[i] = pat(14'(i));
        reset_n = 1'b0; vga_req = 1'b0; vga_a = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_a = '0; cpu_di = '0;
        test_reset();
        test_cpu_write_read();
        test_simultaneous();
        test_scanout();
        test_guard();
        test_reset_inflight();
        test_back_to_back_raw();
        repeat (4) tick();
        n_tests++;
        if (vga_q.size() != 0) begin
            n_fail++;
            $display("FAIL vga_drain: got %0d outstanding fetches, want 0", vga_q.size());
        end
        n_tests++;
        if (cpu_q.size() != 0) begin
            n_fail++;
            $display("FAIL cpu_drain: got %0d outstanding ops, want 0", cpu_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
